pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU result and store-data fields.
REQ-002 Parameter DEST_W, default 4, width of the destination register index.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-low (rst=0 sampled at a clk rising edge resets the block).
REQ-006 Port flush  in  1  kill all held and incoming entries this cycle.
REQ-007 Port in_valid  in  1  upstream entry present.
REQ-008 Port in_ready  out  1  block can accept an entry this cycle.
REQ-009 Port in_wb_en, in_mem_r_en, in_mem_w_en  in  1 each  control bits of the entry.
REQ-010 Port in_alu_res, in_val_rm  in  DATA_W each  ALU result and store data.
REQ-011 Port in_dest  in  DEST_W  destination register index.
REQ-012 Port out_valid  out  1  downstream entry present.
REQ-013 Port out_ready  in  1  downstream consumes the entry this cycle.
REQ-014 Port out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  masked control bits.
REQ-015 Port out_alu_res, out_val_rm  out  DATA_W each; out_dest  out  DEST_W  payload of the head entry.
REQ-016 Port occupancy  out  2  number of held entries (0, 1 or 2).
REQ-017 Port stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 The block SHALL hold at most two entries: a main register (head, drives outputs) and a skid register.
REQ-019 The block SHALL have states EMPTY (0 entries), ONE (main only), FULL (main+skid); occupancy SHALL equal 0/1/2 accordingly.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from registered state only (no combinational path from out_ready).
REQ-021 Accept SHALL mean in_valid=1, in_ready=1, flush=0; pop SHALL mean out_valid=1, out_ready=1.
REQ-022 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-023 EMPTY: accept -> ONE, main loaded; else stay EMPTY.
REQ-024 ONE: accept+pop -> ONE, main loaded with new entry; pop only -> EMPTY; accept only -> FULL, skid loaded; neither -> ONE, main unchanged.
REQ-025 FULL: pop -> ONE, main loaded from skid; no pop -> FULL, both unchanged.
REQ-026 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-027 Latency SHALL be one cycle: an entry accepted in EMPTY appears with out_valid=1 in the next cycle.
REQ-028 flush=1 SHALL force next state EMPTY regardless of in_valid, out_ready or current state, and SHALL take priority over accept; a pop in the same cycle still counts as consumed downstream.
REQ-029 out_wb_en, out_mem_r_en, out_mem_w_en SHALL equal the head's stored bits ANDed with out_valid (never 1 when empty).
REQ-030 out_alu_res, out_val_rm, out_dest SHALL hold the last main-register value while EMPTY (not cleared, except by reset).
REQ-031 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-032 With rst=0 at a rising edge, state SHALL become EMPTY; all payload and control registers, skid included, SHALL become 0; stall_cnt SHALL become 0.
REQ-033 After reset: out_valid=0, in_ready=1, occupancy=0, all out_* =0.
REQ-034 Reset SHALL override flush and any simultaneous accept/pop; entries in flight mid-operation are discarded.

Verification
REQ-035 Reset then in_valid=1, alu_res=0x0000_00A5, dest=3, wb_en=1, out_ready=1 -> next cycle out_valid=1, out_alu_res=0xA5, out_dest=3, out_wb_en=1.
REQ-036 out_ready=0, push A then B -> occupancy 1 then 2, in_ready=0; raise out_ready -> A then B on consecutive cycles, then out_valid=0.
REQ-037 FULL (A,B), flush=1 with in_valid=1 (C) -> next cycle occupancy=0, out_valid=0, controls 0; C never appears.
REQ-038 ONE, accept+pop same cycle, streamed 100 entries with out_ready=1 -> one entry out per cycle, order preserved, occupancy stays 1.
REQ-039 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; flush leaves 15; rst=0 clears to 0.
REQ-040 Assert rst=0 while FULL with out_ready=1 -> next cycle occupancy=0, out_alu_res=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer and a saturating stall counter.
// in_ready is decoded from registered state only, so nothing combinational runs from out_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
  } entry_t;

  state_e           state_q;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_entry;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             accept;
  logic             pop;

  assign in_entry = '{
    wb_en:    in_wb_en,
    mem_r_en: in_mem_r_en,
    mem_w_en: in_mem_w_en,
    alu_res:  in_alu_res,
    val_rm:   in_val_rm,
    dest:     in_dest
  };

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      // Flush drops the state only; payload stays visible (masked) until overwritten.
      if (flush) begin
        state_q <= StEmpty;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              main_q  <= in_entry;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (accept && pop) begin
              main_q <= in_entry;
            end else if (pop) begin
              state_q <= StEmpty;
            end else if (accept) begin
              skid_q  <= in_entry;
              state_q <= StFull;
            end
          end
          StFull: begin
            if (pop) begin
              main_q  <= skid_q;
              state_q <= StOne;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_wb_en    = main_q.wb_en    & out_valid;
  assign out_mem_r_en = main_q.mem_r_en & out_valid;
  assign out_mem_w_en = main_q.mem_w_en & out_valid;
  assign out_alu_res  = main_q.alu_res;
  assign out_val_rm   = main_q.val_rm;
  assign out_dest     = main_q.dest;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, latency, skid ordering, flush, streaming, stall count.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 4;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic              in_mem_w_en;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_val_rm;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic              out_mem_r_en;
  logic              out_mem_w_en;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_val_rm;
  logic [DEST_W-1:0] out_dest;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int total;
  int bad;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .DEST_W (DEST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wb_en     (in_wb_en),
    .in_mem_r_en  (in_mem_r_en),
    .in_mem_w_en  (in_mem_w_en),
    .in_alu_res   (in_alu_res),
    .in_val_rm    (in_val_rm),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wb_en    (out_wb_en),
    .out_mem_r_en (out_mem_r_en),
    .out_mem_w_en (out_mem_w_en),
    .out_alu_res  (out_alu_res),
    .out_val_rm   (out_val_rm),
    .out_dest     (out_dest),
    .occupancy    (occupancy),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [3:0] dest,
                        input logic wb, input logic mr, input logic mw);
    in_valid    = v;
    in_alu_res  = alu;
    in_val_rm   = ~alu;
    in_dest     = dest;
    in_wb_en    = wb;
    in_mem_r_en = mr;
    in_mem_w_en = mw;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    // Reset state
    check("rst_occ",    64'(occupancy),   64'h0);
    check("rst_ovalid", 64'(out_valid),   64'h0);
    check("rst_iready", 64'(in_ready),    64'h1);
    check("rst_alu",    64'(out_alu_res), 64'h0);
    check("rst_wb",     64'(out_wb_en),   64'h0);
    check("rst_stall",  64'(stall_cnt),   64'h0);
    rst = 1'b1;

    // One-cycle latency
    out_ready = 1'b1;
    set_in(1'b1, 32'h0000_00A5, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("lat_ovalid", 64'(out_valid),   64'h1);
    check("lat_alu",    64'(out_alu_res), 64'hA5);
    check("lat_rm",     64'(out_val_rm),  64'hFFFF_FF5A);
    check("lat_dest",   64'(out_dest),    64'h3);
    check("lat_wb",     64'(out_wb_en),   64'h1);
    check("lat_occ",    64'(occupancy),   64'h1);
    step();
    check("drain_ovalid", 64'(out_valid),   64'h0);
    check("drain_wbmask", 64'(out_wb_en),   64'h0);
    check("drain_hold",   64'(out_alu_res), 64'hA5);

    // Skid fill then drain in order
    out_ready = 1'b0;
    set_in(1'b1, 32'h111, 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    check("skid_occ1", 64'(occupancy), 64'h1);
    check("skid_rdy1", 64'(in_ready),  64'h1);
    set_in(1'b1, 32'h222, 4'd2, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("skid_occ2",  64'(occupancy),    64'h2);
    check("skid_rdy2",  64'(in_ready),     64'h0);
    check("skid_headA", 64'(out_alu_res),  64'h111);
    check("skid_mrA",   64'(out_mem_r_en), 64'h1);
    check("skid_stall", 64'(stall_cnt),    64'h1);
    out_ready = 1'b1;
    step();
    check("skid_headB", 64'(out_alu_res),  64'h222);
    check("skid_destB", 64'(out_dest),     64'h2);
    check("skid_mwB",   64'(out_mem_w_en), 64'h1);
    check("skid_mrB",   64'(out_mem_r_en), 64'h0);
    check("skid_occB",  64'(occupancy),    64'h1);
    step();
    check("skid_empty", 64'(out_valid), 64'h0);
    check("skid_occ0",  64'(occupancy), 64'h0);

    // Flush from FULL beats a simultaneous accept
    out_ready = 1'b0;
    set_in(1'b1, 32'h333, 4'd5, 1'b1, 1'b1, 1'b1);
    step();
    set_in(1'b1, 32'h444, 4'd6, 1'b1, 1'b0, 1'b0);
    step();
    check("fl_full", 64'(occupancy), 64'h2);
    flush = 1'b1;
    set_in(1'b1, 32'h555, 4'd7, 1'b1, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("fl_occ",    64'(occupancy),    64'h0);
    check("fl_ovalid", 64'(out_valid),    64'h0);
    check("fl_wb",     64'(out_wb_en),    64'h0);
    check("fl_mr",     64'(out_mem_r_en), 64'h0);
    check("fl_mw",     64'(out_mem_w_en), 64'h0);
    check("fl_iready", 64'(in_ready),     64'h1);
    check("fl_stall",  64'(stall_cnt),    64'h3);
    out_ready = 1'b1;
    step();
    step();
    check("fl_noC_valid", 64'(out_valid),   64'h0);
    check("fl_noC_alu",   64'(out_alu_res), 64'h333);

    // Streaming: accept and pop every cycle
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, 32'h1000 + 32'(i), 4'(i), 1'b0, 1'b0, 1'b0);
      step();
      check("st_valid", 64'(out_valid),   64'h1);
      check("st_alu",   64'(out_alu_res), 64'h1000 + 64'(i));
      check("st_occ",   64'(occupancy),   64'h1);
    end
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("st_end", 64'(out_valid), 64'h0);

    // Stall counter saturation
    out_ready = 1'b0;
    set_in(1'b1, 32'h777, 4'd1, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("sat_mid", 64'(stall_cnt), 64'd13);
    for (int i = 0; i < 10; i++) step();
    check("sat_top", 64'(stall_cnt), 64'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_flush", 64'(stall_cnt), 64'd15);
    check("sat_fl_occ", 64'(occupancy), 64'h0);

    // Reset while FULL with a pending pop and accept
    set_in(1'b1, 32'h888, 4'd2, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h999, 4'd3, 1'b0, 1'b1, 1'b0);
    step();
    check("rf_full", 64'(occupancy), 64'h2);
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 32'hAAA, 4'd4, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("rf_occ",    64'(occupancy),   64'h0);
    check("rf_alu",    64'(out_alu_res), 64'h0);
    check("rf_rm",     64'(out_val_rm),  64'h0);
    check("rf_iready", 64'(in_ready),    64'h1);
    check("rf_stall",  64'(stall_cnt),   64'h0);
    step();
    check("rf_stays_empty", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
